ffre_sig_capture: RTL and testbench



---
 rtl/ffre_pkg.sv | 14 +
 rtl/ffre_misr.sv | 38 +++
 rtl/ffre_sig_capture.sv | 103 ++++++++++
 tb/tb_ffre_sig_capture.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ffre_pkg.sv
// Shared types and defaults for the ffre signature-capture block and the ffre stimulus generator.
package ffre_pkg;

  localparam int unsigned DEF_SIG_W = 32;
  localparam logic [DEF_SIG_W-1:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [DEF_SIG_W-1:0] DEF_SEED = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ffre_misr.sv
// Galois-feedback MISR: loads the seed on request, folds one data word in per shift enable.
module ffre_misr
  import ffre_pkg::*;
#(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned SIG_W = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED = DEF_SEED
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_next;

  // Shift left, apply polynomial when the MSB falls out, then fold in the zero-extended sample.
  always_comb begin
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ SIG_W'(data);
    if (sig[SIG_W-1]) begin
      sig_next = sig_next ^ POLY;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (shift) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/ffre_sig_capture.sv
// Compacts a programmed number of valid ffre bank samples into a MISR signature and
// reports pass/fail against a latched golden value.
module ffre_sig_capture
  import ffre_pkg::*;
#(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned SIG_W = DEF_SIG_W,
  parameter int unsigned CNT_W = 16,
  parameter logic [SIG_W-1:0] POLY = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED = DEF_SEED
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [SIG_W-1:0] expect_sig,
  input  logic [WIDTH-1:0] a_in,
  input  logic             a_vld,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             pass,
  output logic             fail
);

  state_t           state;
  state_t           state_next;
  logic             start_ok;
  logic             accept;
  logic             last;
  logic [CNT_W-1:0] num_lat;
  logic [SIG_W-1:0] expect_lat;

  // Next-state logic; a start is only honoured outside RUN.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = (num_samples != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (a_vld) begin
          accept = 1'b1;
          if ((sample_cnt + CNT_W'(1)) == num_lat) begin
            last       = 1'b1;
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sample counter and run configuration latched on an accepted start.
  always_ff @(posedge clk) begin
    if (clr) begin
      sample_cnt <= '0;
      num_lat    <= '0;
      expect_lat <= '0;
    end else if (start_ok) begin
      sample_cnt <= '0;
      num_lat    <= num_samples;
      expect_lat <= expect_sig;
    end else if (accept) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

  ffre_misr #(
    .WIDTH (WIDTH),
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .clr   (clr),
    .load  (start_ok),
    .shift (accept),
    .data  (a_in),
    .sig   (sig)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (sig == expect_lat);
  assign fail = done && (sig != expect_lat);

endmodule

// File: tb/tb_ffre_sig_capture.sv
// Directed checks of ffre_sig_capture: reset, compaction, feedback wrap, gaps, restart.
module tb_ffre_sig_capture;

  logic        clk;
  logic        clr;
  logic        start;
  logic [15:0] num_samples;
  logic [31:0] expect_sig;
  logic [20:0] a_in;
  logic        a_vld;
  logic        busy;
  logic        done;
  logic [31:0] sig;
  logic [15:0] sample_cnt;
  logic        pass;
  logic        fail;

  int checks = 0;
  int errors = 0;

  ffre_sig_capture dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .num_samples (num_samples),
    .expect_sig  (expect_sig),
    .a_in        (a_in),
    .a_vld       (a_vld),
    .busy        (busy),
    .done        (done),
    .sig         (sig),
    .sample_cnt  (sample_cnt),
    .pass        (pass),
    .fail        (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic b, input logic d,
                            input logic p, input logic f);
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_pass"}, 32'(pass), 32'(p));
    chk({tag, "_fail"}, 32'(fail), 32'(f));
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; num_samples = '0; expect_sig = '0; a_in = '0; a_vld = 1'b0;
    cyc();
    clr = 1'b0;
    chk("rst_sig", sig, 32'h0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a run.
    start = 1'b1; num_samples = 16'd10; expect_sig = 32'h0;
    cyc();
    start = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    a_vld = 1'b1; a_in = 21'h1;
    cyc(3);
    chk("mid_sig3", sig, 32'h7);
    chk("mid_cnt3", 32'(sample_cnt), 32'd3);
    a_vld = 1'b0; clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("mid_rst_sig", sig, 32'h0);
    chk("mid_rst_cnt", 32'(sample_cnt), 32'd0);
    chk_status("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    a_vld = 1'b1; a_in = 21'h5;
    cyc(2);
    chk("idle_vld_sig", sig, 32'h0);
    chk("idle_vld_cnt", 32'(sample_cnt), 32'd0);
    // clr wins over start and a_vld in the same cycle.
    clr = 1'b1; start = 1'b1; num_samples = 16'd4;
    cyc();
    clr = 1'b0; start = 1'b0; a_vld = 1'b0;
    chk_status("clr_prio", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_prio_sig", sig, 32'h0);

    // Basic 3-sample compaction with matching golden value.
    start = 1'b1; num_samples = 16'd3; expect_sig = 32'h7;
    cyc();
    start = 1'b0;
    a_vld = 1'b1; a_in = 21'h1;
    cyc(2);
    chk("basic_sig2", sig, 32'h3);
    chk("basic_done2", 32'(done), 32'd0);
    cyc();
    a_vld = 1'b0;
    chk("basic_sig", sig, 32'h7);
    chk("basic_cnt", 32'(sample_cnt), 32'd3);
    chk_status("basic", 1'b0, 1'b1, 1'b1, 1'b0);
    a_vld = 1'b1; a_in = 21'h1;
    cyc(2);
    a_vld = 1'b0;
    chk("done_vld_sig", sig, 32'h7);
    chk_status("done_hold", 1'b0, 1'b1, 1'b1, 1'b0);

    // Same data against a wrong golden value, then a zero-length restart from DONE.
    start = 1'b1; num_samples = 16'd3; expect_sig = 32'hDEADBEEF;
    cyc();
    start = 1'b0;
    a_vld = 1'b1; a_in = 21'h1;
    cyc(3);
    a_vld = 1'b0;
    chk("mis_sig", sig, 32'h7);
    chk_status("mis", 1'b0, 1'b1, 1'b0, 1'b1);
    start = 1'b1; num_samples = 16'd0; expect_sig = 32'h0;
    cyc();
    start = 1'b0;
    chk("zero_sig", sig, 32'h0);
    chk("zero_cnt", 32'(sample_cnt), 32'd0);
    chk_status("zero", 1'b0, 1'b1, 1'b1, 1'b0);

    // Feedback wrap: a single 1 shifted to the MSB, then folded with POLY.
    start = 1'b1; num_samples = 16'd33; expect_sig = 32'h04C11DB7;
    cyc();
    start = 1'b0;
    a_vld = 1'b1; a_in = 21'h1;
    cyc();
    a_in = 21'h0;
    cyc(31);
    chk("wrap_sig32", sig, 32'h80000000);
    chk("wrap_cnt32", 32'(sample_cnt), 32'd32);
    chk("wrap_busy32", 32'(busy), 32'd1);
    cyc();
    a_vld = 1'b0;
    chk("wrap_sig", sig, 32'h04C11DB7);
    chk_status("wrap", 1'b0, 1'b1, 1'b1, 1'b0);

    // Gaps in a_vld, ignored start mid-run, start coincident with the final sample.
    start = 1'b1; num_samples = 16'd4; expect_sig = 32'h0;
    cyc();
    start = 1'b0;
    a_vld = 1'b1; a_in = 21'h1FFFFF;
    cyc();
    chk("gap_sig1", sig, 32'h001FFFFF);
    chk("gap_cnt1", 32'(sample_cnt), 32'd1);
    a_vld = 1'b0;
    cyc();
    chk("gap_idle_sig", sig, 32'h001FFFFF);
    a_vld = 1'b1;
    cyc();
    chk("gap_sig2", sig, 32'h00200001);
    chk("gap_cnt2", 32'(sample_cnt), 32'd2);
    a_vld = 1'b0; start = 1'b1; num_samples = 16'd7;
    cyc();
    start = 1'b0;
    chk("run_start_busy", 32'(busy), 32'd1);
    chk("run_start_cnt", 32'(sample_cnt), 32'd2);
    chk("run_start_sig", sig, 32'h00200001);
    a_vld = 1'b1; a_in = 21'h0;
    cyc();
    chk("gap_sig3", sig, 32'h00400002);
    start = 1'b1; num_samples = 16'd5;
    cyc();
    start = 1'b0; a_vld = 1'b0;
    chk("last_start_sig", sig, 32'h00800004);
    chk("last_start_cnt", 32'(sample_cnt), 32'd4);
    chk_status("last_start", 1'b0, 1'b1, 1'b0, 1'b1);
    cyc();
    chk_status("last_start_hold", 1'b0, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
